// File: rtl/i2c_codec_target_if.sv
// ----------------------------------------------------------------------------
// i2c_codec_target_if
// Bundles the I2C pins and the register-write side of the codec control-port
// model so the target and its surroundings share one connection.
//
// Signals:
//   i2c_scl      bus clock from the master (asynchronous to i2c_clk)
//   i2c_sda_in   SDA as seen on the pin (asynchronous to i2c_clk)
//   i2c_sda_oe   1 = target pulls SDA low, 0 = released
//   wr_valid     one-cycle strobe for an accepted register write
//   wr_addr      7-bit codec register address, held until the next write
//   wr_data      9-bit codec register data, held until the next write
//   busy         1 from START until the target is back in IDLE
//   frame_error  one-cycle pulse when a frame is cut short by STOP/START
//   state_dbg    current FSM state encoding, for monitors and checkers
//
// Handshake: wr_valid is a pure strobe with no ready/backpressure. wr_addr
// and wr_data are valid in the cycle wr_valid is high and stay unchanged
// afterwards, so a consumer must take the write in that cycle.
//
// Modports:
//   slave  - the target (this block drives SDA-enable and the write port)
//   master - the surroundings (drive the pins, observe the write port)
// ----------------------------------------------------------------------------
interface i2c_codec_target_if;
    logic       i2c_scl;
    logic       i2c_sda_in;
    logic       i2c_sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       frame_error;
    logic [2:0] state_dbg;

    modport slave (
        input  i2c_scl,
        input  i2c_sda_in,
        output i2c_sda_oe,
        output wr_valid,
        output wr_addr,
        output wr_data,
        output busy,
        output frame_error,
        output state_dbg
    );

    modport master (
        output i2c_scl,
        output i2c_sda_in,
        input  i2c_sda_oe,
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  frame_error,
        input  state_dbg
    );
endinterface

// File: rtl/i2c_codec_target.sv
// ----------------------------------------------------------------------------
// i2c_codec_target
// I2C target modelling the audio codec control port. Decodes 3-byte write
// frames (device address + W, then 7-bit register address + 9-bit data),
// ACKs the three bytes by pulling SDA low and emits a one-cycle register
// write strobe per accepted frame. Bytes past the third are NACKed.
//
// Ports:
//   i2c_clk  system clock, at least 16x SCL
//   reset    synchronous, active-high
//   bus      i2c_codec_target_if.slave (pins, write port, busy, errors,
//            state_dbg)
// ----------------------------------------------------------------------------
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic                  i2c_clk,
    input  logic                  reset,
    i2c_codec_target_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    // Synchronizers: meta flop, synced (_s) and delayed (_d) copies.
    logic scl_m_q, scl_s_q, scl_d_q;
    logic sda_m_q, sda_s_q, sda_d_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;

    logic       sda_oe_q, sda_oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       frame_error_q, frame_error_d;

    logic       rise, fall, start_ev, stop_ev;
    logic [7:0] rx_byte;
    logic       last_bit;
    logic       truncated;

    assign rise     = scl_s_q & ~scl_d_q;
    assign fall     = ~scl_s_q & scl_d_q;
    assign start_ev = scl_s_q & scl_d_q & sda_d_q & ~sda_s_q;
    assign stop_ev  = scl_s_q & scl_d_q & ~sda_d_q & sda_s_q;

    // Byte as it will stand once the bit arriving on this rise is shifted in.
    assign rx_byte  = {shift_q, sda_s_q};
    assign last_bit = rise && (cnt_q == 3'd7);

    // A frame is cut short if it stops anywhere before the last data byte
    // has been fully received. ADDR with no bits yet is a clean restart.
    assign truncated = ((state_q == ADDR) && (cnt_q != 3'd0)) ||
                       (state_q == ACK_A) || (state_q == BYTE1) ||
                       (state_q == ACK_1) || (state_q == BYTE2);

    // State and datapath registers.
    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            scl_m_q       <= 1'b1;
            scl_s_q       <= 1'b1;
            scl_d_q       <= 1'b1;
            sda_m_q       <= 1'b1;
            sda_s_q       <= 1'b1;
            sda_d_q       <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            shift_q       <= 7'd0;
            byte1_q       <= 8'd0;
            sda_oe_q      <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= 7'd0;
            wr_data_q     <= 9'd0;
            frame_error_q <= 1'b0;
        end else begin
            scl_m_q       <= bus.i2c_scl;
            scl_s_q       <= scl_m_q;
            scl_d_q       <= scl_s_q;
            sda_m_q       <= bus.i2c_sda_in;
            sda_s_q       <= sda_m_q;
            sda_d_q       <= sda_s_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            byte1_q       <= byte1_d;
            sda_oe_q      <= sda_oe_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte1_d = byte1_q;
        if (stop_ev) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else if (start_ev) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ADDR, BYTE1, BYTE2: begin
                    if (rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;   // wraps to 0 for the next byte
                    end
                    if (last_bit) begin
                        if (state_q == ADDR) begin
                            state_d = (rx_byte == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                        end else if (state_q == BYTE1) begin
                            byte1_d = rx_byte;
                            state_d = ACK_1;
                        end else begin
                            state_d = ACK_2;
                        end
                    end
                end
                // sda_oe_q doubles as the ACK phase: a fall while it is
                // already driven is the end of the ACK slot.
                ACK_A:   if (fall && sda_oe_q) state_d = BYTE1;
                ACK_1:   if (fall && sda_oe_q) state_d = BYTE2;
                ACK_2:   if (fall && sda_oe_q) state_d = IGNORE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output logic (registered through the _d/_q pairs above).
    always_comb begin
        sda_oe_d      = sda_oe_q;
        wr_valid_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_error_d = 1'b0;
        if (stop_ev || start_ev) begin
            sda_oe_d      = 1'b0;
            frame_error_d = truncated;
        end else begin
            case (state_q)
                ACK_A, ACK_1, ACK_2: begin
                    // First fall grabs SDA, second fall releases it.
                    if (fall) sda_oe_d = ~sda_oe_q;
                end
                BYTE2: begin
                    sda_oe_d = 1'b0;
                    if (last_bit) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = byte1_q[7:1];
                        wr_data_d  = {byte1_q[0], rx_byte};
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign bus.i2c_sda_oe  = sda_oe_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.state_dbg   = state_q;

endmodule
